// File: rtl/eeprom_i2c_burst_ctrl.sv
// eeprom_i2c_burst_ctrl: I2C master for 24Cxx EEPROMs with page-write and sequential-read bursts.
// Each bit slot is four ticks of CLK_DIV cycles: SCL low, rise, high (sample), fall.
module eeprom_i2c_burst_ctrl #(
    parameter int         ADDR_W  = 11,
    parameter logic [3:0] DEV_ID  = 4'b1010,
    parameter logic [2:0] DEV_SEL = 3'b000,
    parameter int         CLK_DIV = 4,
    parameter int         LEN_W   = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              RW,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [LEN_W-1:0]  LEN,
    input  logic [7:0]        WDATA,
    output logic              WDATA_REQ,
    output logic [7:0]        RDATA,
    output logic              RDATA_VALID,
    output logic              BUSY,
    output logic              DONE,
    output logic              NACK_ERR,
    output logic              SCL,
    output logic              SDA_OE,
    input  logic              SDA_IN
);
    localparam bit TWO_B = ADDR_W > 11;
    localparam int CW = $clog2(CLK_DIV);
    typedef enum logic [3:0] {IDLE, STA, DEVW, ADDRH, ADDRL, WR, RSTA, DEVR, RD, MACK, STO, FIN} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [1:0] q;
    logic [3:0] bc, byte_last;
    logic [LEN_W-1:0] left;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0] a16;
    logic [7:0] wbuf, rx, tx;
    logic [2:0] sel;
    logic rw_r, err, nak, run, tick, slot_end, ack_slot, mid;
    assign a16 = 16'(addr_r);
    assign sel = TWO_B ? DEV_SEL : a16[10:8];
    assign run = state != IDLE && state != FIN;
    assign tick = run && cnt == CW'(CLK_DIV - 1);
    assign slot_end = tick && q == 2'd3;
    assign ack_slot = bc == 4'd8;
    assign byte_last = state == RD ? 4'd7 : 4'd8;
    assign mid = q[0] ^ q[1];
    assign BUSY = state != IDLE;
    assign DONE = state == FIN;
    assign NACK_ERR = DONE && err;
    // The first cycle of a write byte passes WDATA straight through so SDA is right from Q0
    assign WDATA_REQ = state == WR && bc == 4'd0 && q == 2'd0 && cnt == '0;
    always_comb begin
        tx = state == DEVW  ? {DEV_ID, sel, 1'b0} :
             state == DEVR  ? {DEV_ID, sel, 1'b1} :
             state == ADDRH ? a16[15:8] :
             state == ADDRL ? a16[7:0] :
             WDATA_REQ      ? WDATA : wbuf;
    end
    always_comb begin
        SCL = 1'b1;
        SDA_OE = 1'b0;
        case (state)
            STA: begin
                SCL = ~q[1];
                SDA_OE = q != 2'd0;
            end
            RSTA: begin
                SCL = mid;
                SDA_OE = q[1];
            end
            STO: begin
                SCL = q != 2'd0;
                SDA_OE = ~q[1];
            end
            DEVW, ADDRH, ADDRL, WR, DEVR: begin
                SCL = mid;
                SDA_OE = !ack_slot && !tx[3'd7 - bc[2:0]];
            end
            RD: SCL = mid;
            MACK: begin
                SCL = mid;
                SDA_OE = left != '0;
            end
            default: ;
        endcase
    end
    always_comb begin
        nxt = state;
        if (state == IDLE)
            nxt = START ? STA : IDLE;
        else if (state == FIN)
            nxt = IDLE;
        else if (slot_end)
            case (state)
                STA:   nxt = DEVW;
                DEVW:  nxt = !ack_slot ? DEVW : nak ? STO : TWO_B ? ADDRH : ADDRL;
                ADDRH: nxt = !ack_slot ? ADDRH : nak ? STO : ADDRL;
                ADDRL: nxt = !ack_slot ? ADDRL : nak ? STO : rw_r ? RSTA : WR;
                WR:    nxt = !ack_slot ? WR : (nak || left == '0) ? STO : WR;
                RSTA:  nxt = DEVR;
                DEVR:  nxt = !ack_slot ? DEVR : nak ? STO : RD;
                RD:    nxt = bc == 4'd7 ? MACK : RD;
                MACK:  nxt = left == '0 ? STO : RD;
                STO:   nxt = FIN;
                default: nxt = IDLE;
            endcase
    end
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) state <= IDLE;
        else state <= nxt;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
            q <= '0;
            bc <= '0;
            left <= '0;
            addr_r <= '0;
            rw_r <= 1'b0;
            err <= 1'b0;
            nak <= 1'b0;
            wbuf <= '0;
            rx <= '0;
            RDATA <= '0;
            RDATA_VALID <= 1'b0;
        end else begin
            cnt <= (tick || !run) ? '0 : cnt + 1'b1;
            q <= !run ? 2'd0 : tick ? q + 2'd1 : q;
            if (!run || (slot_end && (nxt != state || bc == byte_last)))
                bc <= '0;
            else if (slot_end)
                bc <= bc + 4'd1;
            RDATA_VALID <= 1'b0;
            if (state == IDLE && START) begin
                addr_r <= ADDR;
                rw_r <= RW;
                left <= LEN;
                err <= 1'b0;
            end else if (slot_end && ack_slot && nak)
                err <= 1'b1;
            if (slot_end && ((state == WR && ack_slot) || state == MACK) && left != '0)
                left <= left - 1'b1;
            if (tick && q == 2'd2 && ack_slot)
                nak <= SDA_IN;
            if (WDATA_REQ)
                wbuf <= WDATA;
            if (state == RD && tick && q == 2'd2) begin
                rx <= {rx[6:0], SDA_IN};
                if (bc == 4'd7) begin
                    RDATA <= {rx[6:0], SDA_IN};
                    RDATA_VALID <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_eeprom_i2c_burst_ctrl.sv
// tb_eeprom_i2c_burst_ctrl: directed bench with a behavioural EEPROM slave and bus-event scoreboard.
// Two instances (1-byte and 2-byte addressing) share one bus model selected by sel.
module tb_eeprom_i2c_burst_ctrl;
    logic CLK = 1'b0, RESET = 1'b0, START = 1'b0, RW = 1'b0, sel = 1'b0, pull = 1'b0;
    logic [15:0] ADDR = '0;
    logic [3:0] LEN = '0;
    logic [7:0] WDATA = '0;
    logic [7:0] rdata_a, rdata_b, rdata;
    logic req_a, req_b, rv_a, rv_b, busy_a, busy_b, done_a, done_b, ne_a, ne_b, scl_a, scl_b, oe_a, oe_b;
    logic req, rv, busy, done, nerr, scl, oe, sda;
    int tests = 0, fails = 0, req_n = 0, done_n = 0, rv_n = 0, nack_at = -1;
    logic [15:0] exp_q[$];
    logic [7:0] rexp_q[$], rd_src[$], wq[$];
    int bitn = -1, bytei = 0;
    bit rd = 0, rdnext = 0, first = 0;
    logic [7:0] sh = '0, rb = '0;
    logic ps = 1'b1, pd = 1'b1, cs, cd, ne;
    int cyc, r0, d0;

    always #5 CLK = ~CLK;

    eeprom_i2c_burst_ctrl u_a (
        .CLK(CLK), .RESET(RESET), .START(START & ~sel), .RW(RW), .ADDR(ADDR[10:0]), .LEN(LEN),
        .WDATA(WDATA), .WDATA_REQ(req_a), .RDATA(rdata_a), .RDATA_VALID(rv_a), .BUSY(busy_a),
        .DONE(done_a), .NACK_ERR(ne_a), .SCL(scl_a), .SDA_OE(oe_a), .SDA_IN(sda)
    );
    eeprom_i2c_burst_ctrl #(.ADDR_W(16)) u_b (
        .CLK(CLK), .RESET(RESET), .START(START & sel), .RW(RW), .ADDR(ADDR), .LEN(LEN),
        .WDATA(WDATA), .WDATA_REQ(req_b), .RDATA(rdata_b), .RDATA_VALID(rv_b), .BUSY(busy_b),
        .DONE(done_b), .NACK_ERR(ne_b), .SCL(scl_b), .SDA_OE(oe_b), .SDA_IN(sda)
    );

    assign {req, rv, busy, done, nerr, scl, oe, rdata} = sel ?
        {req_b, rv_b, busy_b, done_b, ne_b, scl_b, oe_b, rdata_b} :
        {req_a, rv_a, busy_a, done_a, ne_a, scl_a, oe_a, rdata_a};
    assign sda = ~(oe | pull);

    task automatic check(string tag, logic [15:0] obs, logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic ev(logic [15:0] v);
        if (exp_q.size() > 0) check("bus_event", v, exp_q.pop_front());
        else check("bus_extra", v, 16'hFFFF);
    endtask

    // Show-ahead upstream: advance the byte just after the edge that consumed it
    initial forever begin
        @(negedge CLK);
        if (req) begin
            req_n++;
            @(posedge CLK);
            #1;
            if (wq.size() > 0) wq.delete(0);
            WDATA = wq.size() > 0 ? wq[0] : 8'h00;
        end
    end

    // Slave + bus monitor: S=100, P=200, master-written byte, master ack bit=30x
    initial forever begin
        @(negedge CLK);
        cs = scl;
        cd = sda;
        if (done) done_n++;
        if (rv) begin
            rv_n++;
            if (rexp_q.size() > 0) check("rdata", 16'(rdata), 16'(rexp_q.pop_front()));
            else check("rdata_extra", 16'(rdata), 16'hFFFF);
        end
        if (cs && ps && pd && !cd) begin
            ev(16'h100);
            bitn = -1; bytei = 0; rd = 0; rdnext = 0; first = 1; pull = 0;
        end else if (cs && ps && !pd && cd)
            ev(16'h200);
        else if (cs && !ps) begin
            if (bitn >= 0 && bitn < 8) sh = {sh[6:0], cd};
            else if (bitn == 8 && rd) ev(16'h300 | 16'(cd));
        end else if (!cs && ps) begin
            if (bitn < 7) begin
                bitn++;
                if (rd) pull = ~rb[7 - bitn];
            end else if (bitn == 7) begin
                bitn = 8;
                pull = 0;
                if (!rd) begin
                    ev(16'(sh));
                    pull = bytei != nack_at;
                    if (first && sh[0]) rdnext = 1;
                    first = 0;
                    bytei++;
                end
            end else begin
                bitn = 0;
                if (rdnext || (rd && cd == 1'b0)) begin
                    rd = 1; rdnext = 0;
                    rb = rd_src.size() > 0 ? rd_src.pop_front() : 8'hFF;
                    pull = ~rb[7];
                end else pull = 0;
            end
        end
        ps = cs;
        pd = cd;
    end

    task automatic cmd(logic rw_i, logic [15:0] a, logic [3:0] l);
        @(negedge CLK);
        START = 1; RW = rw_i; ADDR = a; LEN = l;
        @(negedge CLK);
        START = 0;
    endtask

    task automatic wait_done(output logic ne_o, output int cyc_o);
        cyc_o = 0;
        for (int n = 0; n < 20000 && !done; n++) begin
            if (busy) cyc_o++;
            @(negedge CLK);
        end
        check("done_seen", 16'(done), 16'd1);
        ne_o = nerr;
        @(negedge CLK);
        check("busy_after_done", 16'(busy), 16'd0);
    endtask

    initial begin
        #23;
        check("reset_state", 16'({scl, oe, busy, done, nerr, rv, req, rdata}), 16'h4000);
        @(negedge CLK);
        RESET = 1;
        repeat (3) @(negedge CLK);

        // single write
        wq = '{8'hC4}; WDATA = 8'hC4; r0 = req_n;
        exp_q = '{16'h100, 16'hAA, 16'hA3, 16'hC4, 16'h200};
        cmd(0, 16'h05A3, 4'd0);
        wait_done(ne, cyc);
        check("t1_nack", 16'(ne), 16'd0);
        check("t1_cycles", 16'(cyc), 16'd464);
        check("t1_req", 16'(req_n - r0), 16'd1);
        check("t1_left", 16'(exp_q.size()), 16'd0);

        // page write
        wq = '{8'h11, 8'h22, 8'h33, 8'h44}; WDATA = 8'h11; r0 = req_n;
        exp_q = '{16'h100, 16'hA0, 16'h10, 16'h11, 16'h22, 16'h33, 16'h44, 16'h200};
        cmd(0, 16'h0010, 4'd3);
        wait_done(ne, cyc);
        check("t2_nack", 16'(ne), 16'd0);
        check("t2_cycles", 16'(cyc), 16'd896);
        check("t2_req", 16'(req_n - r0), 16'd4);
        check("t2_left", 16'(exp_q.size()), 16'd0);

        // sequential read, 2-byte address
        sel = 1; r0 = rv_n;
        rd_src = '{8'h9E, 8'h01, 8'hFF};
        rexp_q = '{8'h9E, 8'h01, 8'hFF};
        exp_q = '{16'h100, 16'hA0, 16'h12, 16'h34, 16'h100, 16'hA1, 16'h300, 16'h300, 16'h301, 16'h200};
        cmd(1, 16'h1234, 4'd2);
        wait_done(ne, cyc);
        check("t3_nack", 16'(ne), 16'd0);
        check("t3_rv", 16'(rv_n - r0), 16'd3);
        check("t3_left", 16'(exp_q.size() + rexp_q.size()), 16'd0);
        sel = 0;
        repeat (3) @(negedge CLK);

        // device NACK
        nack_at = 0; wq = '{8'h77}; WDATA = 8'h77; r0 = req_n;
        exp_q = '{16'h100, 16'hAA, 16'h200};
        cmd(0, 16'h05A3, 4'd1);
        wait_done(ne, cyc);
        check("t4_nack", 16'(ne), 16'd1);
        check("t4_req", 16'(req_n - r0), 16'd0);
        check("t4_left", 16'(exp_q.size()), 16'd0);
        nack_at = -1;
        repeat (3) @(negedge CLK);

        // reset mid data bit 4
        wq = '{8'h5A, 8'h66}; WDATA = 8'h5A;
        exp_q = '{16'h100, 16'hAA, 16'hA3};
        cmd(0, 16'h05A3, 4'd0);
        for (int n = 0; n < 2000 && !req; n++) @(negedge CLK);
        check("t5_req_seen", 16'(req), 16'd1);
        repeat (50) @(negedge CLK);
        RESET = 0;
        #1;
        check("t5_reset_pins", 16'({scl, oe, busy}), 16'b100);
        check("t5_pre_events", 16'(exp_q.size()), 16'd0);
        exp_q.delete();
        @(negedge CLK);
        RESET = 1;
        repeat (3) @(negedge CLK);
        r0 = req_n;
        exp_q = '{16'h100, 16'hA2, 16'h23, 16'h66, 16'h200};
        cmd(0, 16'h0123, 4'd0);
        wait_done(ne, cyc);
        check("t5_nack", 16'(ne), 16'd0);
        check("t5_req", 16'(req_n - r0), 16'd1);
        check("t5_left", 16'(exp_q.size()), 16'd0);

        // START while busy is ignored
        wq = '{8'hA5}; WDATA = 8'hA5; r0 = req_n; d0 = done_n;
        exp_q = '{16'h100, 16'hAA, 16'hA3, 16'hA5, 16'h200};
        cmd(0, 16'h05A3, 4'd0);
        repeat (30) @(negedge CLK);
        START = 1; RW = 1; ADDR = 16'h0777; LEN = 4'd5;
        @(negedge CLK);
        START = 0;
        wait_done(ne, cyc);
        repeat (20) @(negedge CLK);
        check("t6_nack", 16'(ne), 16'd0);
        check("t6_done_count", 16'(done_n - d0), 16'd1);
        check("t6_req", 16'(req_n - r0), 16'd1);
        check("t6_left", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
